// File: rtl/seq_calc_if.sv
// Handshake and result bus between the operand/switch registers and the
// sequential calculator. The master drives requests and operands; the
// slave (the calculator) drives status and results.
interface seq_calc_if #(
    parameter int WIDTH = 12
);
    logic             start;
    logic [1:0]       ope;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic [3:0]       flags;
    logic [WIDTH+3:0] acc_status;

    modport master (
        output start, ope, A, B,
        input  busy, done, result, remainder, flags, acc_status
    );

    modport slave (
        input  start, ope, A, B,
        output busy, done, result, remainder, flags, acc_status
    );
endinterface

// File: rtl/seq_calc.sv
// Sequential calculator: add/sub finish in the accept cycle, multiply is an
// iterative shift-add (one multiplier bit per cycle, LSB first) and divide is
// iterative restoring (one quotient bit per cycle, MSB first). Results,
// remainder, flags {ovf, div0, zero, neg} and the packed display word are
// registered together and hold until the next accepted request.
module seq_calc #(
    parameter int WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_calc_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits. Returns
    // {quotient_bit, new_partial_remainder}.
    function automatic logic [WIDTH:0] div_step(
        input logic [WIDTH-1:0] prem,
        input logic             next_bit,
        input logic [WIDTH-1:0] divisor
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        shifted = {prem, next_bit};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH] == 1'b0) begin
            div_step = {1'b1, diff[WIDTH-1:0]};
        end else begin
            div_step = {1'b0, shifted[WIDTH-1:0]};
        end
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;

    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   prem_r;

    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   remainder_r;
    logic [3:0]         flags_r;
    logic [WIDTH+3:0]   acc_status_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               last_iter_s;
    logic               wr_out_s;
    logic [WIDTH-1:0]   res_nxt_s;
    logic [WIDTH-1:0]   rem_nxt_s;
    logic [3:0]         flg_nxt_s;

    logic [WIDTH:0]     sum_s;
    logic               a_ge_b_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [WIDTH:0]     div_res_s;
    logic [WIDTH-1:0]   quo_step_s;
    logic [WIDTH-1:0]   prem_step_s;

    // Arithmetic datapath: single-cycle add/sub and one iteration of mul/div.
    always_comb begin
        sum_s       = {1'b0, bus.A} + {1'b0, bus.B};
        a_ge_b_s    = (bus.A >= bus.B);
        if (mplier_r[0] == 1'b1) begin
            acc_step_s = acc_r + mcand_r;
        end else begin
            acc_step_s = acc_r;
        end
        div_res_s   = div_step(prem_r, quo_r[WIDTH-1], mplier_r);
        prem_step_s = div_res_s[WIDTH-1:0];
        quo_step_s  = {quo_r[WIDTH-2:0], div_res_s[WIDTH]};
        last_iter_s = (cnt_r == CNT_LAST);
    end

    // Next-state and output-update decisions for the control FSM.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        wr_out_s    = 1'b0;
        res_nxt_s   = result_r;
        rem_nxt_s   = {WIDTH{1'b0}};
        flg_nxt_s   = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                if (bus.start == 1'b1) begin
                    accept_s = 1'b1;
                    wr_out_s = 1'b1;
                    case (bus.ope)
                        OP_ADD: begin
                            res_nxt_s    = sum_s[WIDTH-1:0];
                            flg_nxt_s[3] = sum_s[WIDTH];
                            flg_nxt_s[1] = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
                            state_nxt_s  = ST_DONE;
                        end
                        OP_SUB: begin
                            if (a_ge_b_s) begin
                                res_nxt_s    = bus.A - bus.B;
                                flg_nxt_s[0] = 1'b0;
                            end else begin
                                res_nxt_s    = bus.B - bus.A;
                                flg_nxt_s[0] = 1'b1;
                            end
                            flg_nxt_s[1] = (bus.A == bus.B);
                            state_nxt_s  = ST_DONE;
                        end
                        OP_MUL: begin
                            state_nxt_s = ST_MUL;
                        end
                        OP_DIV: begin
                            if (bus.B == {WIDTH{1'b0}}) begin
                                res_nxt_s    = {WIDTH{1'b0}};
                                rem_nxt_s    = bus.A;
                                flg_nxt_s[2] = 1'b1;
                                flg_nxt_s[1] = 1'b1;
                                state_nxt_s  = ST_DONE;
                            end else begin
                                state_nxt_s = ST_DIV;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last_iter_s) begin
                    wr_out_s     = 1'b1;
                    res_nxt_s    = acc_step_s[WIDTH-1:0];
                    flg_nxt_s[3] = |acc_step_s[2*WIDTH-1:WIDTH];
                    flg_nxt_s[1] = (acc_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    state_nxt_s  = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (last_iter_s) begin
                    wr_out_s     = 1'b1;
                    res_nxt_s    = quo_step_s;
                    rem_nxt_s    = prem_step_s;
                    flg_nxt_s[1] = (quo_step_s == {WIDTH{1'b0}});
                    state_nxt_s  = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand copies, iteration counter and mul/div working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            prem_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r    <= {CW{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, bus.A};
            mplier_r <= bus.B;
            acc_r    <= {(2*WIDTH){1'b0}};
            quo_r    <= bus.A;
            prem_r   <= {WIDTH{1'b0}};
        end else if (state_r == ST_MUL) begin
            cnt_r    <= last_iter_s ? {CW{1'b0}} : cnt_r + CW'(1);
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            acc_r    <= acc_step_s;
        end else if (state_r == ST_DIV) begin
            cnt_r    <= last_iter_s ? {CW{1'b0}} : cnt_r + CW'(1);
            quo_r    <= quo_step_s;
            prem_r   <= prem_step_s;
        end else begin
            cnt_r    <= {CW{1'b0}};
        end
    end

    // Registered outputs: results/flags/display word update together;
    // busy and done follow the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r     <= {WIDTH{1'b0}};
            remainder_r  <= {WIDTH{1'b0}};
            flags_r      <= 4'b0000;
            acc_status_r <= {(WIDTH+4){1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (wr_out_s) begin
                result_r     <= res_nxt_s;
                remainder_r  <= rem_nxt_s;
                flags_r      <= flg_nxt_s;
                acc_status_r <= {res_nxt_s, flg_nxt_s};
            end else begin
                result_r     <= result_r;
                remainder_r  <= remainder_r;
                flags_r      <= flags_r;
                acc_status_r <= acc_status_r;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result     = result_r;
    assign bus.remainder  = remainder_r;
    assign bus.flags      = flags_r;
    assign bus.acc_status = acc_status_r;

endmodule

// File: doc/seq_calc.md
# seq_calc

Parametrised, clocked successor to the single-shot button calculator. Performs add, subtract, multiply and divide on two WIDTH-bit unsigned operands with a start/done handshake. Multiply is iterative shift-add; divide is iterative restoring. Sits between the switch/operand registers and the 7-segment/LED display path. Produces a result, a remainder, and a packed accumulator/status word in the same layout as the existing display path expects.

## Interface
- WIDTH, 12: operand/result width in bits (≥4); acc_status is WIDTH+4 bits
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- ope  in  2  00 add, 01 sub, 10 mul, 11 div; sampled with start
- A  in  WIDTH  operand A (unsigned); sampled with start
- B  in  WIDTH  operand B (unsigned); sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  sum / magnitude of difference / low product / quotient
- remainder  out  WIDTH  division remainder; 0 for other ops
- flags  out  4  {ovf, div0, zero, neg}
- acc_status  out  WIDTH+4  {result, flags}, registered with result

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1: latch ope/A/B; clear flags and remainder.
  - add/sub: compute immediately, go to DONE.
  - mul: go to MUL.
  - div, B≠0: go to DIV.
  - div, B=0: go to DONE.
- IDLE, start=0: stay.
- add: sum computed in WIDTH+1 bits; result = low WIDTH; ovf = carry.
- sub: A≥B → result=A−B, neg=0; A<B → result=B−A, neg=1.
- mul: 2·WIDTH-bit accumulator; one bit of B per cycle, LSB first, adding A shifted when the bit is 1.
  - Exactly WIDTH iterations.
  - result = low WIDTH bits; ovf = OR of high WIDTH bits.
- div: restoring algorithm, one quotient bit per cycle, MSB first, WIDTH iterations.
  - result = quotient; remainder = remainder.
- div by zero: result=0, remainder=A, div0=1, no iterations.
- zero = (result==0), evaluated on the final result for every op.
- DONE: done=1 for exactly one cycle, then IDLE.
- result/remainder/flags/acc_status hold until the next accepted start updates them.
- start while busy: ignored, not queued; outputs and operation unaffected.
- Operand inputs may change freely after acceptance; the internal copies are used.

## Timing
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, remainder=0, flags=0, acc_status=0; iteration counter=0.
- Reset asserted mid-MUL/DIV aborts immediately; no done pulse follows.
- Start accepted at edge k. Let L=0 for add, sub and div-by-zero; L=WIDTH for mul and div.
  - Results are registered at edge k+L.
  - done=1 during the cycle after edge k+L.
  - busy=1 from edge k until edge k+L+1.
  - state=IDLE at edge k+L+1.
- Throughput:
  - Next start is accepted at edge k+L+1 at the earliest.
  - start held high continuously issues back-to-back ops with one DONE cycle between them.
- Iteration counter counts 0..WIDTH−1 and wraps to 0 on leaving MUL/DIV.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 mid-MUL (cycle 5) → all outputs 0 same cycle; after release, no done; a new add then completes normally.
- Add, WIDTH=12: A=4000, B=200 → done at L=0, result=104, ovf=1, acc_status={104, 4'b1000}. Also A=3, B=4 → result=7, flags=0.
- Sub: A=5, B=9 → result=4, neg=1. A=9, B=9 → result=0, zero=1, neg=0.
- Mul: A=100, B=50 → done exactly 12 cycles after acceptance, result=904, ovf=1. A=63, B=65 → result=4095, ovf=0.
- Div: A=1000, B=7 → result=142, remainder=6, 12-cycle latency. A=5, B=0 → result=0, remainder=5, div0=1, done after 0 iterations.
- Handshake: pulse start with ope=mul, then pulse start with ope=add during MUL → add ignored, single done, mul result intact. Start held high → consecutive ops each produce one done.
